msx_slot_write_capture: RTL and testbench

- Upstream front end for the cartridge bank mapper.
- Samples the raw MSX slot bus on SLOTCLK and qualifies memory-write cycles to this slot.
- Decodes which bank register A[15:12] selects and emits a single-cycle write strobe with register index and data byte.
- The mapper consumes the strobe to update its bank registers. This keeps the mapper free of asynchronous bus handling.

---
 rtl/msx_slot_write_capture.sv | 166 ++++++++++++++++
 tb/tb_msx_slot_write_capture.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_slot_write_capture.sv
// MSX slot bus front end: qualifies memory writes to this slot and emits one bank-register strobe
// per bus cycle. Build option MSXCAP_GLITCH_FILTER_EN enables the FILTER_CYCLES qualify filter.
module msx_slot_write_capture #(
   parameter int unsigned MAPPER_TYPE   = 0,
   parameter int unsigned FILTER_CYCLES = 2
) (
   input  logic       SLOTCLK,
   input  logic       RESET,
   input  logic [3:0] A,
   input  logic [7:0] D,
   input  logic       WR,
   input  logic       MREQ,
   input  logic       IORQ,
   input  logic       RFSH,
   input  logic       EXSLTSL,
   output logic       BANK_WE,
   output logic [1:0] BANK_SEL,
   output logic [7:0] BANK_DATA,
   output logic       BUSY
);

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
      logic       wr;
      logic       mreq;
      logic       iorq;
      logic       rfsh;
      logic       exsltsl;
   } bus_t;

   localparam bus_t BusIdle = '{a: 4'h0, d: 8'h00, wr: 1'b1, mreq: 1'b1, iorq: 1'b1,
                                rfsh: 1'b1, exsltsl: 1'b1};

`ifdef MSXCAP_GLITCH_FILTER_EN
   typedef enum logic [1:0] {StIdle, StQual, StFire, StHold} state_e;
   localparam logic [2:0] FilterLim = 3'(FILTER_CYCLES);
   logic [2:0] qcnt_q;
   logic [2:0] qcnt_inc;
   assign qcnt_inc = qcnt_q + 3'd1;
`else
   typedef enum logic [1:0] {StIdle, StFire, StHold} state_e;
`endif

   state_e     state_q;
   bus_t       s1_q;
   bus_t       s2_q;
   logic       qualified;
   logic       released;
   logic       hit;
   logic [1:0] idx;

   assign qualified = ~s2_q.wr & ~s2_q.mreq & ~s2_q.exsltsl & s2_q.iorq & s2_q.rfsh;
   assign released  = s2_q.wr | s2_q.exsltsl;

   always_comb begin
      hit = 1'b0;
      idx = 2'd0;
      case (MAPPER_TYPE)
         32'd0: begin
            case (s2_q.a)
               4'h5:    begin hit = 1'b1; idx = 2'd0; end
               4'h7:    begin hit = 1'b1; idx = 2'd1; end
               4'h9:    begin hit = 1'b1; idx = 2'd2; end
               4'hB:    begin hit = 1'b1; idx = 2'd3; end
               default: ;
            endcase
         end
         32'd1: begin
            case (s2_q.a)
               4'h6:    begin hit = 1'b1; idx = 2'd1; end
               4'h8:    begin hit = 1'b1; idx = 2'd2; end
               4'hA:    begin hit = 1'b1; idx = 2'd3; end
               default: ;
            endcase
         end
         32'd2: begin
            case (s2_q.a)
               4'h6:    begin hit = 1'b1; idx = 2'd0; end
               4'h7:    begin hit = 1'b1; idx = 2'd1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge SLOTCLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= StIdle;
         s1_q      <= BusIdle;
         s2_q      <= BusIdle;
         BANK_WE   <= 1'b0;
         BANK_SEL  <= 2'd0;
         BANK_DATA <= 8'h00;
         BUSY      <= 1'b0;
`ifdef MSXCAP_GLITCH_FILTER_EN
         qcnt_q    <= 3'd0;
`endif
      end else begin
         // All bus signals share one capture so address, data and strobes stay coherent.
         s1_q    <= bus_t'({A, D, WR, MREQ, IORQ, RFSH, EXSLTSL});
         s2_q    <= s1_q;
         BANK_WE <= 1'b0;
         case (state_q)
            StIdle: begin
               if (qualified) begin
                  BUSY <= 1'b1;
                  if (!hit) begin
                     state_q <= StHold;
                  end else begin
                     BANK_SEL  <= idx;
                     BANK_DATA <= s2_q.d;
`ifdef MSXCAP_GLITCH_FILTER_EN
                     qcnt_q <= 3'd1;
                     if (FilterLim == 3'd1) begin
                        state_q <= StFire;
                        BANK_WE <= 1'b1;
                     end else begin
                        state_q <= StQual;
                     end
`else
                     state_q <= StFire;
                     BANK_WE <= 1'b1;
`endif
                  end
               end
            end
`ifdef MSXCAP_GLITCH_FILTER_EN
            StQual: begin
               if (qualified && hit && (idx == BANK_SEL)) begin
                  BANK_DATA <= s2_q.d;
                  qcnt_q    <= qcnt_inc;
                  if (qcnt_inc == FilterLim) begin
                     state_q <= StFire;
                     BANK_WE <= 1'b1;
                  end
               end else begin
                  // Too short or address moved: treat as a glitch and drop it silently.
                  state_q <= StIdle;
                  qcnt_q  <= 3'd0;
                  BUSY    <= 1'b0;
               end
            end
`endif
            StFire: begin
               state_q <= StHold;
            end
            StHold: begin
               if (released) begin
                  state_q <= StIdle;
                  BUSY    <= 1'b0;
`ifdef MSXCAP_GLITCH_FILTER_EN
                  qcnt_q  <= 3'd0;
`endif
               end
            end
            default: begin
               state_q <= StIdle;
               BUSY    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msx_slot_write_capture.sv
// Bench for msx_slot_write_capture: three mapper decodes share one bus; strobes are compared
// against a sample-sequence reference model.
module tb_msx_slot_write_capture;

   localparam int unsigned FC = 2;
`ifdef MSXCAP_GLITCH_FILTER_EN
   localparam int FEFF = int'(FC);
`else
   localparam int FEFF = 1;
`endif

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
      logic       wr;
      logic       mreq;
      logic       iorq;
      logic       rfsh;
      logic       exs;
   } vec_t;

   logic       SLOTCLK = 1'b0;
   logic       RESET   = 1'b1;
   logic [3:0] A       = 4'h0;
   logic [7:0] D       = 8'h00;
   logic       WR      = 1'b1;
   logic       MREQ    = 1'b1;
   logic       IORQ    = 1'b1;
   logic       RFSH    = 1'b1;
   logic       EXSLTSL = 1'b1;
   logic       we   [3];
   logic [1:0] sel  [3];
   logic [7:0] dat  [3];
   logic       busy [3];

   int total = 0;
   int bad = 0;
   int edge_n = 0;
   int seg_start = 0;
   vec_t seg[$];
   logic [41:0] obs [3][$];
   logic [41:0] expq[$];

   msx_slot_write_capture #(.MAPPER_TYPE(0), .FILTER_CYCLES(FC)) u_mt0 (
      .SLOTCLK(SLOTCLK), .RESET(RESET), .A(A), .D(D), .WR(WR), .MREQ(MREQ), .IORQ(IORQ),
      .RFSH(RFSH), .EXSLTSL(EXSLTSL), .BANK_WE(we[0]), .BANK_SEL(sel[0]),
      .BANK_DATA(dat[0]), .BUSY(busy[0]));
   msx_slot_write_capture #(.MAPPER_TYPE(1), .FILTER_CYCLES(FC)) u_mt1 (
      .SLOTCLK(SLOTCLK), .RESET(RESET), .A(A), .D(D), .WR(WR), .MREQ(MREQ), .IORQ(IORQ),
      .RFSH(RFSH), .EXSLTSL(EXSLTSL), .BANK_WE(we[1]), .BANK_SEL(sel[1]),
      .BANK_DATA(dat[1]), .BUSY(busy[1]));
   msx_slot_write_capture #(.MAPPER_TYPE(2), .FILTER_CYCLES(FC)) u_mt2 (
      .SLOTCLK(SLOTCLK), .RESET(RESET), .A(A), .D(D), .WR(WR), .MREQ(MREQ), .IORQ(IORQ),
      .RFSH(RFSH), .EXSLTSL(EXSLTSL), .BANK_WE(we[2]), .BANK_SEL(sel[2]),
      .BANK_DATA(dat[2]), .BUSY(busy[2]));

   always #5 SLOTCLK = ~SLOTCLK;

   always @(posedge SLOTCLK) edge_n <= edge_n + 1;

   // Log every strobe as {edge it rose on, register, data}.
   always @(negedge SLOTCLK) begin
      for (int m = 0; m < 3; m++) begin
         if (we[m]) obs[m].push_back({32'(edge_n), sel[m], dat[m]});
      end
   end

   function automatic vec_t mkv(input logic [3:0] a, input logic [7:0] d, input logic wr,
                                input logic mreq, input logic iorq, input logic rfsh,
                                input logic exs);
      vec_t v;
      v.a = a; v.d = d; v.wr = wr; v.mreq = mreq; v.iorq = iorq; v.rfsh = rfsh; v.exs = exs;
      return v;
   endfunction

   function automatic vec_t wrv(input logic [3:0] a, input logic [7:0] d);
      return mkv(a, d, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
   endfunction

   function automatic vec_t idle_v();
      return mkv(4'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
   endfunction

   // Mapper register maps written as address arithmetic; {hit, index}.
   function automatic logic [2:0] decode(input int mt, input logic [3:0] a);
      int v;
      v = int'(a);
      if (mt == 0 && v >= 5 && v <= 11 && (v % 2) == 1) return {1'b1, 2'((v - 5) / 2)};
      if (mt == 1 && v >= 6 && v <= 10 && (v % 2) == 0) return {1'b1, 2'((v - 4) / 2)};
      if (mt == 2 && (v == 6 || v == 7)) return {1'b1, 2'(v - 6)};
      return 3'b000;
   endfunction

   function automatic logic qual(input vec_t v);
      return !v.wr && !v.mreq && v.iorq && v.rfsh && !v.exs;
   endfunction

   function automatic int after_release(input int j);
      for (int i = j; i < seg.size(); i++) begin
         if (seg[i].wr || seg[i].exs) return i + 1;
      end
      return seg.size();
   endfunction

   // Scan the recorded samples: a write commits after FEFF consecutive qualified samples with
   // one register; the sample after commit is ignored and a release sample ends the bus cycle.
   function automatic void build_expect(input int mt);
      int k;
      int run;
      int last;
      logic [2:0] h;
      expq.delete();
      k = 0;
      while (k < seg.size()) begin
         h = decode(mt, seg[k].a);
         if (!qual(seg[k])) begin
            k++;
         end else if (!h[2]) begin
            k = after_release(k + 1);
         end else begin
            run = 1;
            while (run < FEFF && k + run < seg.size() && qual(seg[k + run]) &&
                   decode(mt, seg[k + run].a) == h) run++;
            if (run == FEFF) begin
               last = k + FEFF - 1;
               expq.push_back({32'(seg_start + last + 2), h[1:0], seg[last].d});
               k = after_release(last + 2);
            end else begin
               k = k + run + 1;
            end
         end
      end
   endfunction

   task automatic drive(input vec_t v);
      @(negedge SLOTCLK);
      if (seg.size() == 0) seg_start = edge_n + 1;
      A = v.a; D = v.d; WR = v.wr; MREQ = v.mreq; IORQ = v.iorq; RFSH = v.rfsh; EXSLTSL = v.exs;
      seg.push_back(v);
   endtask

   task automatic drive_n(input vec_t v, input int n);
      repeat (n) drive(v);
   endtask

   task automatic seg_begin();
      seg.delete();
      for (int m = 0; m < 3; m++) obs[m].delete();
   endtask

   task automatic drain();
      drive_n(idle_v(), 8);
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(negedge SLOTCLK);
      for (int m = 0; m < 3; m++) begin
         total++;
         if ({we[m], sel[m], dat[m], busy[m]} !== 12'h000) begin
            bad++;
            $display("FAIL reset_state u%0d: got we=%b sel=%0d data=%h busy=%b want all 0",
                     m, we[m], sel[m], dat[m], busy[m]);
         end
      end
      RESET = 1'b0;
      repeat (3) begin
         @(negedge SLOTCLK);
         for (int m = 0; m < 3; m++) begin
            total++;
            if (busy[m] !== 1'b0 || we[m] !== 1'b0) begin
               bad++;
               $display("FAIL post_reset_idle u%0d: got busy=%b we=%b want 0 0", m, busy[m], we[m]);
            end
         end
      end
   endtask

   task automatic test_single_write();
      logic [41:0] got;
      seg_begin();
      drive_n(wrv(4'h7, 8'h15), 3);
      drain();
      got = (obs[0].size() > 0) ? obs[0][0] : 42'h0;
      total++;
      if (obs[0].size() != 1 || got !== {32'(seg_start + 1 + FEFF), 2'd1, 8'h15}) begin
         bad++;
         $display("FAIL single_u0: got n=%0d first=%h want n=1 first=%h", obs[0].size(), got,
                  {32'(seg_start + 1 + FEFF), 2'd1, 8'h15});
      end
      for (int m = 0; m < 3; m++) begin
         build_expect(m);
         total++;
         if (obs[m].size() != expq.size()) begin
            bad++;
            $display("FAIL single_count u%0d: got %0d want %0d", m, obs[m].size(), expq.size());
         end else for (int i = 0; i < expq.size(); i++) begin
            total++;
            if (obs[m][i] !== expq[i]) begin
               bad++;
               $display("FAIL single_strobe u%0d #%0d: got %h want %h", m, i, obs[m][i], expq[i]);
            end
         end
      end
   endtask

   task automatic test_glitch();
      seg_begin();
      drive(wrv(4'h7, 8'h15));
      drain();
      for (int m = 0; m < 3; m++) begin
         build_expect(m);
         total++;
         if (obs[m].size() != expq.size()) begin
            bad++;
            $display("FAIL glitch_count u%0d: got %0d want %0d", m, obs[m].size(), expq.size());
         end else for (int i = 0; i < expq.size(); i++) begin
            total++;
            if (obs[m][i] !== expq[i]) begin
               bad++;
               $display("FAIL glitch_strobe u%0d #%0d: got %h want %h", m, i, obs[m][i], expq[i]);
            end
         end
         total++;
         if (busy[m] !== 1'b0) begin
            bad++;
            $display("FAIL glitch_busy u%0d: got %b want 0", m, busy[m]);
         end
      end
   endtask

   task automatic test_mapper_konami();
      logic [41:0] got;
      seg_begin();
      drive_n(wrv(4'h5, 8'h33), 4);
      // Konami has no register at 5xxx: that write must park in the hold state.
      total++;
      if (busy[1] !== 1'b1) begin
         bad++;
         $display("FAIL konami_hold_busy: got %b want 1", busy[1]);
      end
      drive_n(idle_v(), 2);
      drive_n(wrv(4'hA, 8'h0C), FEFF + 1);
      drain();
      got = (obs[1].size() > 0) ? obs[1][obs[1].size() - 1] : 42'h0;
      total++;
      if (obs[1].size() != 1 || got[9:0] !== {2'd3, 8'h0C}) begin
         bad++;
         $display("FAIL konami_u1: got n=%0d sel/data=%h want n=1 sel/data=%h", obs[1].size(),
                  got[9:0], {2'd3, 8'h0C});
      end
      for (int m = 0; m < 3; m++) begin
         build_expect(m);
         total++;
         if (obs[m].size() != expq.size()) begin
            bad++;
            $display("FAIL konami_count u%0d: got %0d want %0d", m, obs[m].size(), expq.size());
         end else for (int i = 0; i < expq.size(); i++) begin
            total++;
            if (obs[m][i] !== expq[i]) begin
               bad++;
               $display("FAIL konami_strobe u%0d #%0d: got %h want %h", m, i, obs[m][i], expq[i]);
            end
         end
      end
   endtask

   task automatic test_disqualified();
      seg_begin();
      drive_n(mkv(4'h9, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3);
      drive_n(idle_v(), 2);
      drive_n(mkv(4'h9, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 3);
      drive_n(idle_v(), 2);
      drive_n(mkv(4'h9, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), 3);
      drain();
      for (int m = 0; m < 3; m++) begin
         total++;
         if (obs[m].size() != 0) begin
            bad++;
            $display("FAIL disqualified u%0d: got %0d strobes want 0", m, obs[m].size());
         end
      end
   endtask

   task automatic test_async_reset();
      seg_begin();
      drive(wrv(4'h7, 8'h5A));
      drive(wrv(4'h7, 8'h5A));
      @(posedge SLOTCLK);
      @(posedge SLOTCLK);
      #2;
      total++;
      if (busy[0] !== 1'b1) begin
         bad++;
         $display("FAIL areset_inflight: got busy=%b want 1", busy[0]);
      end
      RESET = 1'b1;
      #1;
      for (int m = 0; m < 3; m++) begin
         total++;
         if ({we[m], sel[m], dat[m], busy[m]} !== 12'h000) begin
            bad++;
            $display("FAIL areset_outputs u%0d: got we=%b sel=%0d data=%h busy=%b want all 0",
                     m, we[m], sel[m], dat[m], busy[m]);
         end
      end
      A = 4'h0; D = 8'h00; WR = 1'b1; MREQ = 1'b1; IORQ = 1'b1; RFSH = 1'b1; EXSLTSL = 1'b1;
      repeat (2) @(negedge SLOTCLK);
      RESET = 1'b0;
      seg_begin();
      drain();
      for (int m = 0; m < 3; m++) begin
         total++;
         if (obs[m].size() != 0 || busy[m] !== 1'b0) begin
            bad++;
            $display("FAIL areset_cancel u%0d: got %0d strobes busy=%b want 0 0", m,
                     obs[m].size(), busy[m]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [41:0] g0;
      logic [41:0] g1;
      seg_begin();
      drive_n(wrv(4'h5, 8'h01), FEFF + 1);
      drive(idle_v());
      drive_n(wrv(4'hB, 8'h02), FEFF + 1);
      drain();
      g0 = (obs[0].size() > 0) ? obs[0][0] : 42'h0;
      g1 = (obs[0].size() > 1) ? obs[0][1] : 42'h0;
      total++;
      if (obs[0].size() != 2 || g0[9:0] !== {2'd0, 8'h01} || g1[9:0] !== {2'd3, 8'h02}) begin
         bad++;
         $display("FAIL b2b_u0: got n=%0d %h %h want n=2 %h %h", obs[0].size(), g0[9:0],
                  g1[9:0], {2'd0, 8'h01}, {2'd3, 8'h02});
      end
      for (int m = 0; m < 3; m++) begin
         build_expect(m);
         total++;
         if (obs[m].size() != expq.size()) begin
            bad++;
            $display("FAIL b2b_count u%0d: got %0d want %0d", m, obs[m].size(), expq.size());
         end else for (int i = 0; i < expq.size(); i++) begin
            total++;
            if (obs[m][i] !== expq[i]) begin
               bad++;
               $display("FAIL b2b_strobe u%0d #%0d: got %h want %h", m, i, obs[m][i], expq[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      vec_t v;
      seg_begin();
      repeat (60) begin
         v.a    = 4'($urandom_range(0, 15));
         v.d    = 8'($urandom);
         v.wr   = ($urandom_range(0, 9) < 2);
         v.mreq = ($urandom_range(0, 9) < 1);
         v.iorq = ($urandom_range(0, 9) >= 1);
         v.rfsh = ($urandom_range(0, 9) >= 1);
         v.exs  = ($urandom_range(0, 9) < 2);
         drive_n(v, int'($urandom_range(1, 4)));
         drive_n(idle_v(), int'($urandom_range(0, 2)));
      end
      drain();
      for (int m = 0; m < 3; m++) begin
         build_expect(m);
         total++;
         if (obs[m].size() != expq.size()) begin
            bad++;
            $display("FAIL random_count u%0d: got %0d want %0d", m, obs[m].size(), expq.size());
         end else for (int i = 0; i < expq.size(); i++) begin
            total++;
            if (obs[m][i] !== expq[i]) begin
               bad++;
               $display("FAIL random_strobe u%0d #%0d: got %h want %h", m, i, obs[m][i], expq[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_glitch();
      test_mapper_konami();
      test_disqualified();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
